rv_fetch_align: RTL and testbench
=================================

# rv_fetch_align

Parametrised fetch aligner between the instruction SRAM/fetch port and decode. Accepts fetch words of configurable width into a circular halfword queue and extracts one aligned instruction per cycle (16-bit compressed or 32-bit). Tracks the instruction PC, including 32-bit instructions that straddle fetch-word boundaries. Expands compressed instructions through the existing `rv16torv32` converter. Discards stale data on a branch/jump redirect and supports fetch targets at any halfword offset.

## Interface
- `FETCH_W`, 64: fetch word width in bits; legal values 32, 64, 128. `NHW` = `FETCH_W/16`.
- `QDEPTH`, 8: halfword queue depth; power of 2, ≥ 2·`NHW`.
- `RVC_EN`, 1: 1 = compressed instructions are supported; 0 = every instruction is 32-bit.
- `RESET_PC`, 32'h0: PC after reset; bit 0 must be 0.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `flush` input 1: redirect; discard all queued and in-flight data.
- `flush_pc` input 32: redirect target, halfword aligned.
- `in_valid` input 1: fetch word present.
- `in_ready` output 1: aligner can accept a fetch word.
- `in_data` input `FETCH_W`: fetch word, little-endian halfwords.
- `out_valid` output 1: a complete instruction is at the queue head.
- `out_ready` input 1: decode consumes the instruction.
- `out_instr` output 32: expanded 32-bit instruction.
- `out_raw` output 32: raw bits; for a 16-bit instruction, upper half is zero.
- `out_pc` output 32: PC of `out_instr`.
- `out_rv16` output 1: the instruction was compressed.

## Operation
- State:
  - queue `q[QDEPTH]` of 16-bit entries;
  - head and tail pointers of log2(`QDEPTH`) bits, wrapping modulo `QDEPTH`;
  - `count` of log2(`QDEPTH`)+1 bits;
  - `skip` of log2(`NHW`) bits;
  - `pc_r` of 32 bits.
- Reset values:
  - `count`=0, head=tail=0;
  - `pc_r`=`RESET_PC`;
  - `skip`=`RESET_PC`[log2(`NHW`):1].
  - Outputs after reset: `out_valid`=0, `in_ready`=1, `out_pc`=`RESET_PC`, `out_rv16`=0, `out_raw`/`out_instr` don't-care (queue contents are not reset).
- Push:
  - `in_ready` = (`QDEPTH` − `count` ≥ `NHW`) & ~`flush`.
  - On `in_valid & in_ready`, halfwords `skip`..`NHW`−1 of `in_data` are written at the tail, lowest index first; tail and `count` advance by `NHW`−`skip`.
  - `skip` is then cleared to 0.
- Head decode:
  - `h0` = `q[head]`, `h1` = `q[head+1]`.
  - The head instruction is long when `RVC_EN`=0 or `h0`[1:0]==2'b11.
  - `out_valid` = ~`flush` & (long ? `count`≥2 : `count`≥1).
  - Long: `out_raw`={`h1`,`h0`}, `out_instr`=`out_raw`, `out_rv16`=0.
  - Compressed: `out_raw`={16'h0,`h0`}, `out_instr`=`rv16torv32`(`h0`), `out_rv16`=1.
- Pop:
  - On `out_valid & out_ready`, head advances by 2 (long) or 1 (compressed).
  - `pc_r` advances by 4 or 2, with 32-bit wrap.
  - `out_pc`=`pc_r`.
- Simultaneous push and pop: `count` ← `count` + pushed − popped, in a single update. Free-space check uses the pre-pop `count`.
- Flush (highest priority):
  - `count`←0, head←tail;
  - `pc_r`←`flush_pc`;
  - `skip`←`flush_pc`[log2(`NHW`):1];
  - any push or pop in the same cycle is ignored.
  - The fetch unit's first word after a flush is the word containing `flush_pc`.
- Boundary-straddling 32-bit instruction: the lower half is held in the queue and `out_valid` stays 0 until the next fetch word supplies the upper half. No stall beyond that word's arrival.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous).

## Timing
- A fetch word accepted in cycle N produces `out_valid` in cycle N+1 at the earliest. The output is combinational from registered queue state.
- Throughput: one instruction per cycle when the queue holds a complete instruction.
- `in_ready` and `out_valid` have no combinational path from `in_valid` or `out_ready`. `in_ready` depends only on `count` and `flush`. `out_valid` depends only on queue state and `flush`.
- After a flush in cycle N, `out_valid`=0 in N and N+1. The first redirected instruction is visible in N+2 at the earliest, assuming the fetch word arrives in N+1.
- `rv16torv32` is combinational and sits inside the output path.

## Test plan
- Reset, `FETCH_W`=64, `RESET_PC`=0: push {32'h00A00093, 32'h00000513}.
  - Expect instruction 00A00093 at PC 0 in cycle 1 and 00000513 at PC 4 in cycle 2, both with `out_rv16`=0.
  - Then `out_valid`=0 with `count`=0.
- Mixed compressed stream: push halfwords 4501, 0505, 0093, 00A0.
  - Expect two compressed outputs (expanded by `rv16torv32`) at PC 0 and 2, then 00A00093 at PC 4.
- Straddle: push word with halfwords [4501,4501,4501,0093], then word [00A0,...].
  - Expect `out_valid`=0 after the third compressed instruction until the second word is accepted.
  - Then 00A00093 at PC 6.
- Flush with `flush_pc`=32'h106, coincident with `in_valid` and `out_ready`.
  - Expect nothing pushed or popped and `out_valid`=0.
  - The next word's halfwords 0–2 are discarded; first output at PC 0x106.
- Backpressure, `QDEPTH`=8, `out_ready`=0: push two words.
  - Expect `in_ready`=0 once `count`=8, and no overwrite.
  - Release `out_ready`: 8 compressed instructions pop in order and `in_ready` returns to 1 when `count`≤4.
  - Head and tail wrap correctly.
- Reset mid-stream with `count`=5: assert `rst_n`=0 asynchronously.
  - Expect `out_valid`=0 and `in_ready`=1 immediately, and `out_pc`=`RESET_PC`.

Source files
------------

// File: rtl/rv_fetch_align.sv
// rv_fetch_align: halfword-queue fetch aligner delivering one 16/32-bit instruction per cycle to decode
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_flush, i_flush_pc             redirect and its halfword-aligned target
//   i_in_valid, o_in_ready, i_in_data   fetch word handshake, little-endian halfwords
//   o_out_valid, i_out_ready        instruction handshake
//   o_out_instr, o_out_raw          expanded instruction, raw bits (upper half zero when compressed)
//   o_out_pc, o_out_rv16            instruction PC, compressed flag
module rv_fetch_align #(
  parameter int FETCH_W = 64,
  parameter int QDEPTH = 8,
  parameter bit RVC_EN = 1'b1,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic [31:0]        i_flush_pc,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [FETCH_W-1:0] i_in_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [31:0]        o_out_instr,
  output logic [31:0]        o_out_raw,
  output logic [31:0]        o_out_pc,
  output logic               o_out_rv16
);
  localparam int NHW = FETCH_W / 16;
  localparam int AW = $clog2(QDEPTH);
  localparam int SW = $clog2(NHW);
  localparam logic [AW:0] CNT_LIM = (AW+1)'(QDEPTH - NHW);
  logic [15:0]   r_q [QDEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0]   r_count;
  logic [SW-1:0] r_skip;
  logic [31:0]   r_pc;
  logic [AW-1:0] w_head1;
  logic [15:0]   w_h0, w_h1;
  logic          w_long, w_push, w_pop;
  logic [AW:0]   w_npush, w_npop;
  logic [31:0]   w_exp;
  assign w_head1 = r_head + AW'(1);
  assign w_h0 = r_q[r_head];
  assign w_h1 = r_q[w_head1];
  assign w_long = !RVC_EN || w_h0[1:0] == 2'b11;
  assign o_out_valid = ~i_flush & (w_long ? r_count > (AW+1)'(1) : r_count != '0);
  // free space is judged on the pre-pop count so in_ready never depends on out_ready
  assign o_in_ready = ~i_flush & (r_count <= CNT_LIM);
  assign w_push = i_in_valid & o_in_ready;
  assign w_pop = o_out_valid & i_out_ready;
  // the first word after a redirect only contributes halfwords at and above the target
  assign w_npush = (AW+1)'(NHW) - (AW+1)'(r_skip);
  assign w_npop = w_long ? (AW+1)'(2) : (AW+1)'(1);
  assign o_out_raw = w_long ? {w_h1, w_h0} : {16'h0, w_h0};
  assign o_out_instr = w_long ? o_out_raw : w_exp;
  // gated on occupancy because the queue storage is not reset
  assign o_out_rv16 = ~w_long & (r_count != '0);
  assign o_out_pc = r_pc;
  rv16torv32 u_exp (
    .i_instr(w_h0),
    .o_instr(w_exp)
  );
  always_ff @(posedge clk)
    for (int i = 0; i < NHW; i++)
      if (w_push && SW'(i) >= r_skip)
        r_q[r_tail + AW'(i) - AW'(r_skip)] <= i_in_data[16*i +: 16];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_skip  <= RESET_PC[SW:1];
      r_pc    <= RESET_PC;
    end else if (i_flush) begin
      r_head  <= r_tail;
      r_count <= '0;
      r_skip  <= i_flush_pc[SW:1];
      r_pc    <= i_flush_pc;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + AW'(w_npush);
        r_skip <= '0;
      end
      if (w_pop) begin
        r_head <= r_head + AW'(w_npop);
        r_pc   <= r_pc + (w_long ? 32'd4 : 32'd2);
      end
      r_count <= r_count + (w_push ? w_npush : '0) - (w_pop ? w_npop : '0);
    end
endmodule

// rv16torv32: combinational RV32C to RV32I expander; illegal encodings map to 32'h0
// Ports:
//   i_instr  16-bit compressed instruction
//   o_instr  equivalent 32-bit instruction
module rv16torv32 (
  input  logic [15:0] i_instr,
  output logic [31:0] o_instr
);
  logic [15:0] c;
  logic [4:0]  w_rd, w_rs2, w_rdp, w_rs1p;
  logic [31:0] w_jal, w_alu;
  assign c = i_instr;
  assign w_rd = c[11:7];
  assign w_rs2 = c[6:2];
  assign w_rdp = {2'b01, c[4:2]};
  assign w_rs1p = {2'b01, c[9:7]};
  // shared by C.JAL (link x1) and C.J (link x0); c[15] tells them apart
  assign w_jal = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], c[12], {8{c[12]}},
                  4'b0, ~c[15], 7'b1101111};
  // C.SRLI / C.SRAI / C.ANDI / register-register group; c[6:5] selects SUB/XOR/OR/AND
  assign w_alu = c[11:10] == 2'b00 ? {7'b0, c[6:2], w_rs1p, 3'b101, w_rs1p, 7'b0010011} :
                 c[11:10] == 2'b01 ? {7'b0100000, c[6:2], w_rs1p, 3'b101, w_rs1p, 7'b0010011} :
                 c[11:10] == 2'b10 ? {{7{c[12]}}, c[6:2], w_rs1p, 3'b111, w_rs1p, 7'b0010011} :
                 c[12] ? 32'h0 :
                 {c[6:5] == 2'b00 ? 7'b0100000 : 7'b0, w_rdp, w_rs1p,
                  c[6] | c[5], c[6], c[6] & c[5], w_rs1p, 7'b0110011};
  always_comb begin
    o_instr = 32'h0;
    case ({c[15:13], c[1:0]})
      5'b000_00: o_instr = c[12:5] == 8'h0 ? 32'h0 :
                           {2'b0, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, w_rdp, 7'b0010011};
      5'b010_00: o_instr = {5'b0, c[5], c[12:10], c[6], 2'b00, w_rs1p, 3'b010, w_rdp, 7'b0000011};
      5'b110_00: o_instr = {5'b0, c[5], c[12], w_rdp, w_rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'b0100011};
      5'b000_01: o_instr = {{7{c[12]}}, c[6:2], w_rd, 3'b000, w_rd, 7'b0010011};
      5'b001_01: o_instr = w_jal;
      5'b010_01: o_instr = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, w_rd, 7'b0010011};
      5'b011_01: o_instr = w_rd == 5'd2 ?
                           {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, 7'b0010011} :
                           {{15{c[12]}}, c[6:2], w_rd, 7'b0110111};
      5'b100_01: o_instr = w_alu;
      5'b101_01: o_instr = w_jal;
      5'b110_01,
      5'b111_01: o_instr = {{4{c[12]}}, c[6:5], c[2], 5'd0, w_rs1p, 2'b00, c[13],
                            c[11:10], c[4:3], c[12], 7'b1100011};
      5'b000_10: o_instr = {7'b0, c[6:2], w_rd, 3'b001, w_rd, 7'b0010011};
      5'b010_10: o_instr = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, w_rd, 7'b0000011};
      5'b100_10: o_instr = !c[12] ?
                           (w_rs2 == 5'd0 ? {12'b0, w_rd, 3'b000, 5'd0, 7'b1100111} :
                                            {7'b0, w_rs2, 5'd0, 3'b000, w_rd, 7'b0110011}) :
                           (w_rs2 != 5'd0 ? {7'b0, w_rs2, w_rd, 3'b000, w_rd, 7'b0110011} :
                            w_rd == 5'd0  ? 32'h00100073 :
                                            {12'b0, w_rd, 3'b000, 5'd1, 7'b1100111});
      5'b110_10: o_instr = {4'b0, c[8:7], c[12], w_rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'b0100011};
      default:   o_instr = 32'h0;
    endcase
  end
endmodule

// File: tb/tb_rv_fetch_align.sv
// tb_rv_fetch_align: random fetch/decode traffic against a program-image reference model
module tb_rv_fetch_align;
  localparam int FETCH_W = 64;
  localparam int QDEPTH = 8;
  localparam int NHW = FETCH_W / 16;
  localparam int NB = FETCH_W / 8;
  localparam int PROG = 1024;
  localparam int MSZ = PROG + 8;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] PC_LIM = 32'(2 * (PROG - 32));
  localparam logic [15:0] CTAB [9] = '{16'h4501, 16'h0505, 16'h852E, 16'h4512, 16'h8082,
                                       16'h0001, 16'h050A, 16'h157D, 16'h41C8};
  localparam logic [31:0] XTAB [9] = '{32'h00000513, 32'h00150513, 32'h00B00533, 32'h00412503,
                                       32'h00008067, 32'h00000013, 32'h00251513, 32'hFFF50513,
                                       32'h0045A503};
  logic clk = 0, rst_n = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_rv16;
  logic [31:0] flush_pc = 0, out_instr, out_raw, out_pc;
  logic [FETCH_W-1:0] in_data = '0;
  int checks = 0, failures = 0;
  logic [15:0] mem [MSZ];
  logic [31:0] xins [MSZ];
  int starts [$];
  logic [31:0] exp_pc, fa;

  always #5 clk = ~clk;

  rv_fetch_align #(.FETCH_W(FETCH_W), .QDEPTH(QDEPTH), .RVC_EN(1'b1), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_flush_pc(flush_pc),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_instr(out_instr),
    .o_out_raw(out_raw), .o_out_pc(out_pc), .o_out_rv16(out_rv16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic put_long(input int p, input logic [31:0] w);
    mem[p] = w[15:0];
    mem[p+1] = w[31:16];
    xins[p] = w;
    if (p < PROG - 64) starts.push_back(p);
  endtask

  task automatic put_short(input int p, input int k);
    mem[p] = CTAB[k];
    xins[p] = XTAB[k];
    if (p < PROG - 64) starts.push_back(p);
  endtask

  function automatic logic [FETCH_W-1:0] fw(input logic [31:0] a);
    for (int i = 0; i < NHW; i++) fw[16*i +: 16] = mem[(int'(a >> 1) + i) % MSZ];
  endfunction

  task automatic rst_checks();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_pc", out_pc, RESET_PC);
    check("rst_out_rv16", out_rv16, 0);
  endtask

  // one cycle: drive at negedge, compare against the program image, then advance the model
  task automatic step(input bit fl, input logic [31:0] fpc, input bit iv, input bit ordy);
    int hi, ln, avail;
    bit xv, xr;
    @(negedge clk);
    flush = fl;
    flush_pc = fpc;
    in_valid = iv;
    out_ready = ordy;
    in_data = fw(fa);
    #1;
    hi = int'(exp_pc >> 1) % MSZ;
    ln = mem[hi][1:0] == 2'b11 ? 2 : 1;
    avail = fa > exp_pc ? int'((fa - exp_pc) >> 1) : 0;
    xv = !fl && avail >= ln;
    xr = !fl && (QDEPTH - avail >= NHW);
    check("in_ready", in_ready, xr);
    check("out_valid", out_valid, xv);
    check("out_pc", out_pc, exp_pc);
    if (xv) begin
      check("out_raw", out_raw, ln == 2 ? {mem[(hi+1) % MSZ], mem[hi]} : {16'h0, mem[hi]});
      check("out_instr", out_instr, xins[hi]);
      check("out_rv16", out_rv16, ln == 1);
    end
    if (fl) begin
      exp_pc = fpc;
      fa = fpc & ~32'(NB - 1);
    end else begin
      if (iv && xr) fa += NB;
      if (xv && ordy) exp_pc += 32'(2 * ln);
    end
  endtask

  task automatic rand_steps(input int n);
    bit fl;
    repeat (n) begin
      fl = $urandom_range(39) == 0 || exp_pc >= PC_LIM;
      step(fl, fl ? 32'(2 * starts[$urandom_range(starts.size() - 1)]) : 32'h0,
           $urandom_range(3) != 0, $urandom_range(3) != 0);
    end
  endtask

  initial begin
    int pos, k;
    for (int i = 0; i < MSZ; i++) begin
      mem[i] = 16'h0;
      xins[i] = 32'h0;
    end
    put_long(0, 32'h00A00093);
    put_long(2, 32'h00000513);
    put_short(4, 0);
    put_short(5, 1);
    put_long(6, 32'h00A00093);
    for (int i = 8; i < 11; i++) put_short(i, 0);
    put_long(11, 32'h00A00093);
    pos = 13;
    while (pos < PROG) begin
      if (pos == 130 || (pos >= 511 && pos < 528) || $urandom_range(1) == 0) begin
        put_short(pos, $urandom_range(8));
        pos++;
      end else begin
        k = $urandom_range(3);
        put_long(pos, k == 0 ? 32'h00A00093 : k == 1 ? 32'h00000513 : ($urandom | 32'h3));
        pos += 2;
      end
    end
    exp_pc = RESET_PC;
    fa = RESET_PC & ~32'(NB - 1);
    #1 rst_n = 0;
    #1 rst_checks();
    repeat (2) @(negedge clk);
    rst_n = 1;
    step(0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    repeat (6) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(1, 32'h106, 1, 1);
    repeat (6) step(0, 0, 1, 1);
    step(1, 32'h400, 0, 0);
    repeat (5) step(0, 0, 1, 0);
    repeat (12) step(0, 0, 1, 1);
    rand_steps(3000);
    step(1, 32'h16, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    #2 rst_n = 0;
    flush = 0;
    in_valid = 0;
    out_ready = 0;
    #1 rst_checks();
    exp_pc = RESET_PC;
    fa = RESET_PC & ~32'(NB - 1);
    @(negedge clk);
    rst_n = 1;
    rand_steps(800);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
